// File: rtl/rx_recv_seq.sv
// UDP RX receiver: parses start/stop, discovery and write-IP commands and forwards EP2 frame
// bytes to the RX FIFO with sequence, sync, overflow and truncation tracking.
module rx_recv_seq #(
  parameter int PORT           = 1024,
  parameter int FRAMES_PER_PKT = 2,
  parameter int FRAME_BYTES    = 512,
  parameter int CNT_W          = 16,
  parameter bit SEQ_CHECK      = 1'b1
) (
  input  logic             rx_clk,
  input  logic             rst_n,
  input  logic [15:0]      to_port,
  input  logic             broadcast,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_fifo_full,
  output logic [7:0]       rx_fifo_data,
  output logic             rx_fifo_enable,
  output logic             frame_start,
  output logic             run,
  output logic             wide_spectrum,
  output logic             discovery_reply,
  output logic             write_ip,
  output logic             seq_err,
  output logic             sync_err,
  output logic [CNT_W-1:0] seq_err_cnt,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] trunc_cnt
);

  // state    | meaning
  // IDLE     | waiting for b0 (EF); only armed once rx_valid has been seen low
  // PRE1     | expecting b1 (FE)
  // PRE2     | command byte b2, dispatch
  // CMD_RUN  | b3 carries run / wide_spectrum bits
  // SEQ      | b3 endpoint check, then b4..b7 big-endian sequence number
  // PAYLOAD  | frame bytes forwarded to the RX FIFO
  // WAIT_END | discard bytes until rx_valid drops
  typedef enum logic [2:0] {IDLE, PRE1, PRE2, CMD_RUN, SEQ, PAYLOAD, WAIT_END} state_t;

  localparam int TOTAL = FRAMES_PER_PKT * FRAME_BYTES;
  localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int KW    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  state_t        state;
  logic          armed;
  logic [2:0]    seq_idx;
  logic [23:0]   seq_shift;
  logic [31:0]   seq_exp;
  logic          seq_valid;
  logic [PW-1:0] pay_left;
  logic [KW-1:0] k_cnt;
  logic          hdr_bad;

  logic          port_ok;
  logic [31:0]   seq_rx;
  logic          hdr_bad_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    port_ok     = (to_port == 16'(PORT));
    seq_rx      = {seq_shift, rx_data};
    // sync flag restarts on the first byte of every frame
    hdr_bad_nxt = ((k_cnt == '0) ? 1'b0 : hdr_bad) | (rx_data != 8'h7F);
  end

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      armed           <= 1'b0;
      seq_idx         <= '0;
      seq_shift       <= '0;
      seq_exp         <= '0;
      seq_valid       <= 1'b0;
      pay_left        <= '0;
      k_cnt           <= '0;
      hdr_bad         <= 1'b0;
      rx_fifo_data    <= '0;
      rx_fifo_enable  <= 1'b0;
      frame_start     <= 1'b0;
      run             <= 1'b0;
      wide_spectrum   <= 1'b0;
      discovery_reply <= 1'b0;
      write_ip        <= 1'b0;
      seq_err         <= 1'b0;
      sync_err        <= 1'b0;
      seq_err_cnt     <= '0;
      sync_err_cnt    <= '0;
      ovf_cnt         <= '0;
      trunc_cnt       <= '0;
    end else begin
      rx_fifo_enable  <= 1'b0;
      frame_start     <= 1'b0;
      discovery_reply <= 1'b0;
      write_ip        <= 1'b0;
      seq_err         <= 1'b0;
      sync_err        <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_valid) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            if (rx_data == 8'hEF && port_ok) state <= PRE1;
          end
        end

        PRE1: begin
          if (!rx_valid) begin
            state <= IDLE;
            armed <= 1'b1;
          end else if (rx_data == 8'hFE && port_ok) begin
            state <= PRE2;
          end else begin
            state <= IDLE;
          end
        end

        PRE2: begin
          if (!rx_valid) begin
            state <= IDLE;
            armed <= 1'b1;
          end else begin
            case (rx_data)
              8'h04: state <= CMD_RUN;
              8'h02: begin
                discovery_reply <= broadcast;
                state           <= WAIT_END;
              end
              8'h03: begin
                write_ip <= broadcast & ~run;
                state    <= WAIT_END;
              end
              8'h01: begin
                seq_idx <= '0;
                state   <= SEQ;
              end
              default: state <= WAIT_END;
            endcase
          end
        end

        CMD_RUN: begin
          if (!rx_valid) begin
            state <= IDLE;
            armed <= 1'b1;
          end else begin
            run           <= rx_data[0];
            wide_spectrum <= rx_data[1];
            state         <= WAIT_END;
          end
        end

        SEQ: begin
          if (!rx_valid) begin
            trunc_cnt <= sat_inc(trunc_cnt);
            state     <= IDLE;
            armed     <= 1'b1;
          end else if (seq_idx == 3'd0) begin
            if (rx_data != 8'h02) state <= WAIT_END;
            else seq_idx <= 3'd1;
          end else if (seq_idx != 3'd4) begin
            seq_shift <= {seq_shift[15:0], rx_data};
            seq_idx   <= seq_idx + 3'd1;
          end else begin
            if (SEQ_CHECK && seq_valid && seq_rx != seq_exp) begin
              seq_err     <= 1'b1;
              seq_err_cnt <= sat_inc(seq_err_cnt);
            end
            seq_exp   <= seq_rx + 32'd1;
            seq_valid <= 1'b1;
            pay_left  <= PW'(TOTAL - 1);
            k_cnt     <= '0;
            state     <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (!rx_valid) begin
            trunc_cnt <= sat_inc(trunc_cnt);
            state     <= IDLE;
            armed     <= 1'b1;
          end else begin
            if (k_cnt < KW'(3)) begin
              hdr_bad <= hdr_bad_nxt;
              if (k_cnt == KW'(2) && hdr_bad_nxt) begin
                sync_err     <= 1'b1;
                sync_err_cnt <= sat_inc(sync_err_cnt);
              end
            end
            // a full FIFO drops the byte but the frame position still advances
            if (!rx_fifo_full) begin
              rx_fifo_enable <= 1'b1;
              rx_fifo_data   <= rx_data;
              frame_start    <= (k_cnt == '0);
            end else begin
              ovf_cnt <= sat_inc(ovf_cnt);
            end
            k_cnt <= (k_cnt == KW'(FRAME_BYTES - 1)) ? '0 : k_cnt + 1'b1;
            if (pay_left == '0) state <= WAIT_END;
            else pay_left <= pay_left - 1'b1;
          end
        end

        WAIT_END: begin
          if (!rx_valid) begin
            state <= IDLE;
            armed <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_recv_seq.sv
// Scoreboard bench for rx_recv_seq: a packet-level reference model queues expected FIFO writes
// and counter values; a negedge monitor pops and compares every write and tallies pulses.
module tb_rx_recv_seq;

  localparam int PORT  = 1024;
  localparam int FPP   = 2;
  localparam int FB    = 512;
  localparam int TOTAL = FPP * FB;
  localparam int CNT_W = 16;

  logic             rx_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic [15:0]      to_port = 16'(PORT);
  logic             broadcast = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_fifo_full = 1'b0;
  logic [7:0]       rx_fifo_data;
  logic             rx_fifo_enable, frame_start, run, wide_spectrum;
  logic             discovery_reply, write_ip, seq_err, sync_err;
  logic [CNT_W-1:0] seq_err_cnt, sync_err_cnt, ovf_cnt, trunc_cnt;

  rx_recv_seq #(.PORT(PORT), .FRAMES_PER_PKT(FPP), .FRAME_BYTES(FB), .CNT_W(CNT_W),
                .SEQ_CHECK(1'b1)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .to_port(to_port), .broadcast(broadcast),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_fifo_full(rx_fifo_full),
    .rx_fifo_data(rx_fifo_data), .rx_fifo_enable(rx_fifo_enable), .frame_start(frame_start),
    .run(run), .wide_spectrum(wide_spectrum), .discovery_reply(discovery_reply),
    .write_ip(write_ip), .seq_err(seq_err), .sync_err(sync_err),
    .seq_err_cnt(seq_err_cnt), .sync_err_cnt(sync_err_cnt), .ovf_cnt(ovf_cnt),
    .trunc_cnt(trunc_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];   // {byte, frame_start}
  logic [8:0] mon_e;
  int writes_seen = 0, seq_pulses = 0, sync_pulses = 0, disc_pulses = 0, wip_pulses = 0;

  bit          m_run = 0, m_wide = 0, m_seq_valid = 0;
  logic [31:0] m_exp = 0;
  int m_seqerr = 0, m_syncerr = 0, m_ovf = 0, m_trunc = 0, m_disc = 0, m_wip = 0, m_writes = 0;

  logic [7:0] pk[$];
  bit         fl[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge rx_clk) begin
    if (rx_fifo_enable) begin
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got data %02h, no write expected", rx_fifo_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e !== {rx_fifo_data, frame_start}) begin
          errors++;
          $display("FAIL fifo_write: got %02h fs=%0b expected %02h fs=%0b",
                   rx_fifo_data, frame_start, mon_e[8:1], mon_e[0]);
        end
      end
    end
    if (frame_start && !rx_fifo_enable) begin
      checks++;
      errors++;
      $display("FAIL frame_start_alone: got 1 expected 0");
    end
    if (seq_err)         seq_pulses++;
    if (sync_err)        sync_pulses++;
    if (discovery_reply) disc_pulses++;
    if (write_ip)        wip_pulses++;
  end

  task automatic build_data(input logic [31:0] seq, input int bad_frame, input int bad_k,
                            input int full_start, input int full_len);
    logic [7:0] b;
    pk = {};
    fl = {};
    pk.push_back(8'hEF); pk.push_back(8'hFE); pk.push_back(8'h01); pk.push_back(8'h02);
    pk.push_back(seq[31:24]); pk.push_back(seq[23:16]);
    pk.push_back(seq[15:8]);  pk.push_back(seq[7:0]);
    for (int i = 0; i < TOTAL; i++) begin
      b = ((i % FB) < 3) ? 8'h7F : 8'($urandom);
      if ((i / FB) == bad_frame && (i % FB) == bad_k) b = 8'h00;
      pk.push_back(b);
    end
    for (int j = 0; j < pk.size(); j++)
      fl.push_back((j >= 8 + full_start) && (j < 8 + full_start + full_len));
  endtask

  task automatic build_cmd(input logic [7:0] cmd, input logic [7:0] b3);
    pk = {8'hEF, 8'hFE, cmd, b3};
    for (int i = 0; i < 4; i++) pk.push_back(8'($urandom));
    fl = {};
    for (int j = 0; j < pk.size(); j++) fl.push_back(1'b0);
  endtask

  // Reference: what the first n bytes of pk should do, from the packet format rules.
  task automatic model_pkt(input logic [15:0] port, input bit bc, input int n);
    logic [31:0] s;
    logic [7:0]  b;
    bit          bad;
    int          k;
    if (n < 3 || pk[0] != 8'hEF || pk[1] != 8'hFE || port != 16'(PORT)) return;
    case (pk[2])
      8'h04: if (n >= 4) begin m_run = pk[3][0]; m_wide = pk[3][1]; end
      8'h02: if (bc) m_disc++;
      8'h03: if (bc && !m_run) m_wip++;
      8'h01: begin
        if (n < 4) begin m_trunc++; return; end
        if (pk[3] != 8'h02) return;
        if (n < 8) begin m_trunc++; return; end
        s = {pk[4], pk[5], pk[6], pk[7]};
        if (m_seq_valid && s != m_exp) m_seqerr++;
        m_exp = s + 32'd1;
        m_seq_valid = 1;
        bad = 0;
        for (int i = 0; i < TOTAL; i++) begin
          if (8 + i >= n) begin m_trunc++; return; end
          b = pk[8 + i];
          k = i % FB;
          if (k == 0) bad = 0;
          if (k < 3 && b != 8'h7F) bad = 1;
          if (k == 2 && bad) m_syncerr++;
          if (fl[8 + i]) m_ovf++;
          else begin
            exp_q.push_back({b, (k == 0) ? 1'b1 : 1'b0});
            m_writes++;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive_pkt(input logic [15:0] port, input bit bc, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rx_clk); #1;
      to_port = port; broadcast = bc;
      rx_valid = 1'b1; rx_data = pk[i]; rx_fifo_full = fl[i];
    end
    @(posedge rx_clk); #1;
    rx_valid = 1'b0; rx_fifo_full = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge rx_clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/seq_err_cnt"},  seq_err_cnt,  m_seqerr);
    chk({tag, "/sync_err_cnt"}, sync_err_cnt, m_syncerr);
    chk({tag, "/ovf_cnt"},      ovf_cnt,      m_ovf);
    chk({tag, "/trunc_cnt"},    trunc_cnt,    m_trunc);
    chk({tag, "/run"},          run,          m_run);
    chk({tag, "/wide"},         wide_spectrum, m_wide);
    chk({tag, "/seq_pulses"},   seq_pulses,   m_seqerr);
    chk({tag, "/sync_pulses"},  sync_pulses,  m_syncerr);
    chk({tag, "/disc_pulses"},  disc_pulses,  m_disc);
    chk({tag, "/wip_pulses"},   wip_pulses,   m_wip);
    chk({tag, "/writes"},       writes_seen,  m_writes);
  endtask

  task automatic send(input string tag, input logic [15:0] port, input bit bc, input int n);
    model_pkt(port, bc, n);
    drive_pkt(port, bc, n);
    check_all(tag);
  endtask

  initial begin
    int kind, n, bf, bk;
    logic [15:0] port;
    bit bc;

    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst/outputs", {rx_fifo_data, rx_fifo_enable, frame_start, run, wide_spectrum,
                        discovery_reply, write_ip, seq_err, sync_err}, 0);
    chk("rst/counters", {seq_err_cnt, sync_err_cnt, ovf_cnt, trunc_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge rx_clk);

    build_data(32'd0, 9, 0, 0, 0);         send("t1_clean", 16'(PORT), 0, pk.size());
    chk("t1/writes1024", writes_seen, 1024);
    build_data(32'd1, 9, 0, 0, 0);         send("t2_seq1", 16'(PORT), 0, pk.size());
    build_data(32'd3, 9, 0, 0, 0);         send("t2_seq3", 16'(PORT), 0, pk.size());
    chk("t2/seq_err_cnt1", seq_err_cnt, 1);
    build_data(32'd4, 9, 0, 0, 0);         send("t2_seq4", 16'(PORT), 0, pk.size());
    build_data(32'd5, 1, 1, 0, 0);         send("t3_sync", 16'(PORT), 0, pk.size());
    chk("t3/sync_err_cnt1", sync_err_cnt, 1);
    build_data(32'd6, 9, 0, 300, 10);      send("t4_ovf", 16'(PORT), 0, pk.size());
    chk("t4/ovf_cnt10", ovf_cnt, 10);
    build_data(32'd7, 9, 0, 0, 0);         send("t5_trunc", 16'(PORT), 0, 8 + 100);
    chk("t5/trunc_cnt1", trunc_cnt, 1);
    build_data(32'd8, 9, 0, 0, 0);         send("t5_after", 16'(PORT), 0, pk.size());

    build_cmd(8'h04, 8'h03);               send("t6_run", 16'(PORT), 0, pk.size());
    build_cmd(8'h03, 8'h00);               send("t6_wip_blocked", 16'(PORT), 1, pk.size());
    build_cmd(8'h02, 8'h00);               send("t6_disc", 16'(PORT), 1, pk.size());
    build_cmd(8'h04, 8'h00);               send("t6_port_run", 16'(PORT + 1), 1, pk.size());
    build_cmd(8'h02, 8'h00);               send("t6_port_disc", 16'(PORT + 1), 1, pk.size());
    build_cmd(8'h02, 8'h00);               send("t6_disc_nobc", 16'(PORT), 0, pk.size());
    build_cmd(8'h04, 8'h00);               send("t6_stop", 16'(PORT), 0, pk.size());
    build_cmd(8'h03, 8'h00);               send("t6_wip", 16'(PORT), 1, pk.size());
    build_cmd(8'h04, 8'h01);               send("t6_run_again", 16'(PORT), 0, pk.size());

    // reset lands mid-packet; the remainder of that packet must be ignored
    build_data(32'd77, 9, 0, 0, 0);
    for (int i = 0; i < pk.size(); i++) begin
      @(posedge rx_clk); #1;
      to_port = 16'(PORT); broadcast = 1'b0;
      rx_valid = 1'b1; rx_data = pk[i]; rx_fifo_full = 1'b0;
      if (i == 6) rst_n = 1'b0;
      if (i == 9) rst_n = 1'b1;
      if (i == 7) begin
        m_run = 0; m_wide = 0; m_seq_valid = 0; m_exp = 0;
        m_seqerr = 0; m_syncerr = 0; m_ovf = 0; m_trunc = 0;
        m_disc = 0; m_wip = 0; m_writes = 0;
        writes_seen = 0; seq_pulses = 0; sync_pulses = 0; disc_pulses = 0; wip_pulses = 0;
      end
    end
    @(posedge rx_clk); #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    check_all("rst_mid");
    build_data(32'd5, 9, 0, 0, 0);         send("after_rst", 16'(PORT), 0, pk.size());

    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 9);
      port = ($urandom_range(0, 7) == 0) ? 16'(PORT + 1) : 16'(PORT);
      bc   = 1'($urandom_range(0, 1));
      case (kind)
        0: build_cmd(8'h04, 8'($urandom));
        1: build_cmd(8'h02, 8'($urandom));
        2: build_cmd(8'h03, 8'($urandom));
        3: build_cmd(8'($urandom_range(5, 255)), 8'h02);
        default: begin
          bf = $urandom_range(0, 2);
          bk = $urandom_range(0, 2);
          build_data(($urandom_range(0, 3) == 0) ? 32'($urandom) : m_exp, bf, bk,
                     $urandom_range(0, TOTAL - 1), $urandom_range(0, 20));
          if ($urandom_range(0, 9) == 0) pk[3] = 8'h03;
        end
      endcase
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, pk.size() - 1) : pk.size();
      send($sformatf("rand%0d", r), port, bc, n);
    end

    chk("final/exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
